// File: rtl/wb_burst_master_if.sv
// rtl/wb_burst_master_if.sv - Wishbone B4 master/slave bus bundle for wb_burst_master.
interface wb_burst_master_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - SDRAM write/read-back burst tester over Wishbone with ack watchdog.
// Optional WBM_INCR_BURST_EN: incrementing bursts (cti 010/111, continuous stb) instead of classic cycles.
module wb_burst_master #(
  parameter int unsigned TOUT_CYC = 1023,
  parameter logic [31:0] PATTERN  = 32'hA5A5_5A5A
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     sdr_init_done,
  input  logic                     start_i,
  input  logic [31:0]              base_addr_i,
  input  logic [7:0]               burst_len_i,
  input  logic [7:0]               num_bursts_i,
  wb_burst_master_if.master        wb,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [15:0]              err_cnt_o,
  output logic [31:0]              first_err_addr_o
);

  typedef enum logic [2:0] {IDLE, WAIT_INIT, WR, RD, DONE} state_t;

  localparam logic [31:0] TOUT_LAST = 32'(TOUT_CYC) - 32'd1;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d, stb_q, stb_d;
  logic [31:0] addr_q, addr_d, base_q, base_d;
  logic [7:0]  len_q, len_d, nb_q, nb_d;
  logic [7:0]  beat_q, beat_d, burst_q, burst_d;
  logic [31:0] wd_q, wd_d;
  logic [15:0] err_q, err_d;
  logic [31:0] ferr_q, ferr_d;
  logic        done_q, done_d, pass_q, pass_d, tout_q, tout_d;

  logic last_beat, last_burst, mismatch;

  assign last_beat  = (beat_q == len_q - 8'd1);
  assign last_burst = (burst_q == nb_q - 8'd1);
  assign mismatch   = (wb.wb_dat_i != (addr_q ^ PATTERN));

  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = stb_q;
  assign wb.wb_we_o   = cyc_q && (state_q == WR);
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = (cyc_q && (state_q == WR)) ? (addr_q ^ PATTERN) : 32'h0;
  assign wb.wb_sel_o  = cyc_q ? 4'hF : 4'h0;
`ifdef WBM_INCR_BURST_EN
  assign wb.wb_cti_o  = !stb_q ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
`else
  assign wb.wb_cti_o  = 3'b000;
`endif

  assign busy_o           = (state_q == WAIT_INIT) || (state_q == WR) || (state_q == RD);
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign timeout_o        = tout_q;
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = ferr_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      addr_q  <= 32'h0;
      base_q  <= 32'h0;
      len_q   <= 8'd1;
      nb_q    <= 8'd1;
      beat_q  <= 8'd0;
      burst_q <= 8'd0;
      wd_q    <= 32'h0;
      err_q   <= 16'h0;
      ferr_q  <= 32'h0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      nb_q    <= nb_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    addr_d  = addr_q;
    base_d  = base_q;
    len_d   = len_q;
    nb_d    = nb_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    wd_d    = wd_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tout_d  = tout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = WAIT_INIT;
          base_d  = base_addr_i;
          len_d   = (burst_len_i == 8'd0) ? 8'd1 : burst_len_i;
          nb_d    = (num_bursts_i == 8'd0) ? 8'd1 : num_bursts_i;
          err_d   = 16'h0;
          ferr_d  = 32'h0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tout_d  = 1'b0;
        end
      end
      WAIT_INIT: begin
        if (sdr_init_done) begin
          state_d = WR;
          addr_d  = base_q;
          beat_d  = 8'd0;
          burst_d = 8'd0;
          wd_d    = 32'h0;
        end
      end
      WR, RD: begin
        // cyc low is the inter-burst gap; stb low with cyc high is the classic post-ack gap
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end else if (!stb_q) begin
          stb_d = 1'b1;
        end else if (wb.wb_ack_i) begin
          wd_d   = 32'h0;
          addr_d = addr_q + 32'd4;
          if ((state_q == RD) && mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'h0) ferr_d = addr_q;
          end
          if (last_beat) begin
            beat_d = 8'd0;
            cyc_d  = 1'b0;
            stb_d  = 1'b0;
            if (last_burst) begin
              burst_d = 8'd0;
              if (state_q == WR) begin
                state_d = RD;
                addr_d  = base_q;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
                pass_d  = (err_d == 16'h0);
              end
            end else begin
              burst_d = burst_q + 8'd1;
            end
          end else begin
            beat_d = beat_q + 8'd1;
`ifdef WBM_INCR_BURST_EN
            stb_d  = 1'b1;
`else
            stb_d  = 1'b0;
`endif
          end
        end else if (wd_q == TOUT_LAST) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          tout_d  = 1'b1;
          pass_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
